// File: rtl/bias_load_multibank.sv
// Bias loader: decodes one 96-bit load instruction, issues one DRAM read and scatters the returned
// stream beats over NUM_BANKS buffer banks. Optional err_status port: define BIAS_LOAD_ERR_STATUS_EN.
module bias_load_multibank #(
  parameter int INST_LENGTH     = 96,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int XFER_SIZE_WIDTH = 32,
  parameter int BUF_ADDR_WIDTH  = 9,
  parameter int NUM_BANKS       = 4
) (
  input  logic                       kernel_clk,
  input  logic                       kernel_rst,
  input  logic                       ap_start,
  output logic                       ap_done,
  input  logic [ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [INST_LENGTH-1:0]     ctrl_instruction,
  output logic                       rd_start,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic [XFER_SIZE_WIDTH-1:0] rd_size,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  output logic [NUM_BANKS-1:0]       buf_wr_valid,
  output logic [BUF_ADDR_WIDTH-1:0]  buf_wr_addr,
  output logic [DATA_WIDTH-1:0]      buf_wr_data
`ifdef BIAS_LOAD_ERR_STATUS_EN
  ,
  output logic [1:0]                 err_status
`endif
);

  localparam int LOG_BANKS = $clog2(NUM_BANKS);
  localparam int BANK_W    = (LOG_BANKS > 0) ? LOG_BANKS : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ISSUE, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t                      r_state;
  logic [1:0]                  r_mode;
  logic [3:0]                  r_bank_id;
  logic [15:0]                 r_start;
  logic [15:0]                 r_count;
  logic [15:0]                 r_dram_off;
  logic [15:0]                 r_length;
  logic [ADDR_WIDTH-1:0]       r_base;
  logic [15:0]                 r_beat_cnt;
  logic                        r_rd_start;
  logic                        r_ap_done;
  logic                        r_tready;
  logic [ADDR_WIDTH-1:0]       r_rd_addr;
  logic [XFER_SIZE_WIDTH-1:0]  r_rd_size;
  logic [NUM_BANKS-1:0]        r_wr_valid;
  logic [BUF_ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]       r_wr_data;
  logic [1:0]                  r_err;

  logic                        w_broadcast;
  logic                        w_interleave;
  logic [BANK_W-1:0]           w_bank_sel;
  logic [BUF_ADDR_WIDTH-1:0]   w_wr_addr;
  logic [NUM_BANKS-1:0]        w_bank_mask;
  logic                        w_last_idx;
  logic                        w_unused;

  // Mode 3 is reserved and falls through to single-bank behaviour.
  assign w_broadcast  = (r_mode == 2'd1);
  assign w_interleave = (r_mode == 2'd2);
  assign w_bank_sel   = w_interleave ? BANK_W'(r_beat_cnt & 16'(NUM_BANKS - 1))
                                     : BANK_W'(r_bank_id & 4'(NUM_BANKS - 1));
  assign w_wr_addr    = BUF_ADDR_WIDTH'(r_start + (w_interleave ? (r_beat_cnt >> LOG_BANKS)
                                                                 : r_beat_cnt));
  assign w_last_idx   = (r_beat_cnt == r_count - 16'd1);

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign w_bank_mask[gi] = w_broadcast || (w_bank_sel == BANK_W'(gi));
  end

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      r_state    <= S_IDLE;
      r_mode     <= '0;
      r_bank_id  <= '0;
      r_start    <= '0;
      r_count    <= '0;
      r_dram_off <= '0;
      r_length   <= '0;
      r_base     <= '0;
      r_beat_cnt <= '0;
      r_rd_start <= 1'b0;
      r_ap_done  <= 1'b0;
      r_tready   <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_size  <= '0;
      r_wr_valid <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_err      <= '0;
    end else begin
      r_rd_start <= 1'b0;
      r_ap_done  <= 1'b0;
      r_wr_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_mode     <= ctrl_instruction[17:16];
            r_bank_id  <= ctrl_instruction[23:20];
            r_start    <= ctrl_instruction[47:32];
            r_count    <= ctrl_instruction[63:48];
            r_dram_off <= ctrl_instruction[79:64];
            r_length   <= ctrl_instruction[95:80];
            r_base     <= ctrl_addr_offset;
            r_state    <= S_LATCH;
          end
        end
        S_LATCH: begin
          r_err      <= '0;
          r_beat_cnt <= '0;
          if (r_count == 16'd0) begin
            r_state <= S_DONE;
          end else begin
            r_rd_start <= 1'b1;
            r_rd_addr  <= r_base + ADDR_WIDTH'(r_dram_off);
            r_rd_size  <= XFER_SIZE_WIDTH'(r_length);
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tready <= 1'b1;
          r_state  <= S_STREAM;
        end
        S_STREAM: begin
          if (s_tvalid) begin
            r_wr_valid <= w_bank_mask;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= s_tdata;
            if (w_last_idx) begin
              if (s_tlast) begin
                r_tready <= 1'b0;
                r_state  <= S_DONE;
              end else begin
                r_err[1] <= 1'b1;
                r_state  <= S_DRAIN;
              end
            end else if (s_tlast) begin
              r_err[0] <= 1'b1;
              r_tready <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 16'd1;
            end
          end
        end
        S_DRAIN: begin
          // Surplus beats are consumed so the read master can finish its burst.
          if (s_tvalid && s_tlast) begin
            r_tready <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_ap_done <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ap_done      = r_ap_done;
  assign rd_start     = r_rd_start;
  assign rd_addr      = r_rd_addr;
  assign rd_size      = r_rd_size;
  assign s_tready     = r_tready;
  assign buf_wr_valid = r_wr_valid;
  assign buf_wr_addr  = r_wr_addr;
  assign buf_wr_data  = r_wr_data;

`ifdef BIAS_LOAD_ERR_STATUS_EN
  assign err_status = r_err;
  assign w_unused   = ^{ctrl_instruction[15:0], ctrl_instruction[19:18], ctrl_instruction[31:24]};
`else
  assign w_unused   = ^{ctrl_instruction[15:0], ctrl_instruction[19:18], ctrl_instruction[31:24], r_err};
`endif

endmodule

// File: tb/tb_bias_load_multibank.sv
// Self-checking bench for bias_load_multibank: directed scenarios plus randomized transactions
// compared against a per-beat mapping model.
`timescale 1ns/1ps
module tb_bias_load_multibank;
  localparam int NB = 4;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 32;
  localparam int BW = 9;
  localparam int IL = 96;

  typedef struct packed {
    logic [NB-1:0] mask;
    logic [BW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          kernel_clk;
  logic          kernel_rst;
  logic          ap_start;
  logic          ap_done;
  logic [AW-1:0] ctrl_addr_offset;
  logic [IL-1:0] ctrl_instruction;
  logic          rd_start;
  logic [AW-1:0] rd_addr;
  logic [XW-1:0] rd_size;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] s_tdata;
  logic [NB-1:0] buf_wr_valid;
  logic [BW-1:0] buf_wr_addr;
  logic [DW-1:0] buf_wr_data;
`ifdef BIAS_LOAD_ERR_STATUS_EN
  logic [1:0]    err_status;
`endif

  bias_load_multibank dut (
    .kernel_clk       (kernel_clk),
    .kernel_rst       (kernel_rst),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ctrl_addr_offset (ctrl_addr_offset),
    .ctrl_instruction (ctrl_instruction),
    .rd_start         (rd_start),
    .rd_addr          (rd_addr),
    .rd_size          (rd_size),
    .s_tvalid         (s_tvalid),
    .s_tready         (s_tready),
    .s_tlast          (s_tlast),
    .s_tdata          (s_tdata),
    .buf_wr_valid     (buf_wr_valid),
    .buf_wr_addr      (buf_wr_addr),
    .buf_wr_data      (buf_wr_data)
`ifdef BIAS_LOAD_ERR_STATUS_EN
    , .err_status     (err_status)
`endif
  );

  initial kernel_clk = 1'b0;
  always #5 kernel_clk = ~kernel_clk;

  int cyc = 0;
  always @(posedge kernel_clk) cyc <= cyc + 1;

  // Passive monitor: records every write, read start and done pulse.
  wr_t           obs_wr[$];
  int            rd_pulses = 0;
  int            done_pulses = 0;
  int            done_cyc = 0;
  logic [AW-1:0] obs_rd_addr = '0;
  logic [XW-1:0] obs_rd_size = '0;
  logic [1:0]    obs_err = '0;

  always @(negedge kernel_clk) begin
    if (!kernel_rst) begin
      if (buf_wr_valid != '0) obs_wr.push_back(wr_t'({buf_wr_valid, buf_wr_addr, buf_wr_data}));
      if (rd_start) begin
        rd_pulses   <= rd_pulses + 1;
        obs_rd_addr <= rd_addr;
        obs_rd_size <= rd_size;
      end
      if (ap_done) begin
        done_pulses <= done_pulses + 1;
        done_cyc    <= cyc;
`ifdef BIAS_LOAD_ERR_STATUS_EN
        obs_err     <= err_status;
`endif
      end
    end
  end

  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW-1:0] sent[$];
  wr_t           exp_wr[$];
  int            wr_base, rd_base, done_base, start_cyc, acc_cyc;
  logic [1:0]    cur_mode;
  logic [3:0]    cur_bank;
  logic [15:0]   cur_s, cur_n, cur_doff, cur_len;
  logic [AW-1:0] cur_off;

  task automatic start_txn(input logic [1:0] mode, input logic [3:0] bank,
                           input logic [15:0] s, input logic [15:0] n);
    cur_mode = mode; cur_bank = bank; cur_s = s; cur_n = n;
    cur_doff = 16'($urandom()); cur_len = 16'($urandom());
    cur_off  = {$urandom(), $urandom()};
    sent.delete();
    wr_base = obs_wr.size(); rd_base = rd_pulses; done_base = done_pulses;
    ctrl_instruction = {$urandom(), $urandom(), $urandom()};
    ctrl_instruction[17:16] = mode;
    ctrl_instruction[23:20] = bank;
    ctrl_instruction[47:32] = s;
    ctrl_instruction[63:48] = n;
    ctrl_instruction[79:64] = cur_doff;
    ctrl_instruction[95:80] = cur_len;
    ctrl_addr_offset = cur_off;
    ap_start  = 1'b1;
    start_cyc = cyc;
    @(posedge kernel_clk); #1;
    ap_start = 1'b0;
    ctrl_instruction = {$urandom(), $urandom(), $urandom()};
    ctrl_addr_offset = {$urandom(), $urandom()};
  endtask

  task automatic send_beats(input int nbeats, input int last_at, input bit toggle, input bit noise);
    logic [DW-1:0] d;
    bit acc;
    ap_start = noise;
    for (int i = 0; i < nbeats; i++) begin
      if (toggle && (i % 2 == 1)) begin
        s_tvalid = 1'b0;
        @(posedge kernel_clk); #1;
      end
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
      s_tvalid = 1'b1; s_tdata = d; s_tlast = (i + 1 == last_at);
      acc = 1'b0;
      for (int w = 0; w < 40 && !acc; w++) begin
        acc = s_tready;
        acc_cyc = cyc;
        @(posedge kernel_clk); #1;
      end
      if (!acc) begin
        n_checks++;
        $display("FAIL beat_accept: beat %0d never accepted, s_tready=%b required 1", i, s_tready);
        break;
      end
      sent.push_back(d);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; ap_start = 1'b0;
  endtask

  task automatic wait_done();
    for (int w = 0; w < 30 && done_pulses == done_base; w++) begin
      @(posedge kernel_clk); #1;
    end
    repeat (3) begin @(posedge kernel_clk); #1; end
  endtask

  // Reference mapping: beat k goes to bank/address derived from the mode with plain arithmetic.
  function automatic void build_expected();
    int nw = (sent.size() < int'(cur_n)) ? sent.size() : int'(cur_n);
    exp_wr.delete();
    for (int k = 0; k < nw; k++) begin
      wr_t e;
      int bank, a;
      if (cur_mode == 2'd1) begin
        e.mask = '1; a = int'(cur_s) + k;
      end else if (cur_mode == 2'd2) begin
        bank = k % NB; a = int'(cur_s) + k / NB; e.mask = NB'(1) << bank;
      end else begin
        bank = int'(cur_bank) % NB; a = int'(cur_s) + k; e.mask = NB'(1) << bank;
      end
      e.addr = BW'(a % (1 << BW));
      e.data = sent[k];
      exp_wr.push_back(e);
    end
  endfunction

  task automatic test_reset();
    kernel_rst = 1'b1; ap_start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    ctrl_instruction = '0; ctrl_addr_offset = '0;
    repeat (3) @(posedge kernel_clk);
    #1;
    n_checks++;
    if ({s_tready, ap_done, rd_start, buf_wr_valid} !== '0)
      $display("FAIL reset_ctrl: tready/done/rd_start/valid=%b required 0", {s_tready, ap_done, rd_start, buf_wr_valid});
    else n_pass++;
    n_checks++;
    if (rd_addr !== '0 || rd_size !== '0)
      $display("FAIL reset_rd: rd_addr=%h rd_size=%h required 0", rd_addr, rd_size);
    else n_pass++;
    n_checks++;
    if (buf_wr_addr !== '0 || buf_wr_data !== '0)
      $display("FAIL reset_wr: addr=%h data[31:0]=%h required 0", buf_wr_addr, buf_wr_data[31:0]);
    else n_pass++;
    kernel_rst = 1'b0;
    repeat (2) begin @(posedge kernel_clk); #1; end
    n_checks++;
    if ({s_tready, ap_done} !== 2'b00) $display("FAIL idle_ctrl: tready/done=%b required 00", {s_tready, ap_done});
    else n_pass++;
    $display("txn reset: done");
  endtask

  task automatic test_single();
    start_txn(2'd0, 4'd2, 16'd10, 16'd4);
    send_beats(4, 4, 1'b0, 1'b0);
    wait_done();
    build_expected();
    n_checks++;
    if (obs_wr.size() - wr_base !== 4) $display("FAIL single_count: got %0d writes required 4", obs_wr.size() - wr_base);
    else n_pass++;
    for (int k = 0; k < exp_wr.size() && wr_base + k < obs_wr.size(); k++) begin
      n_checks++;
      if (obs_wr[wr_base+k] !== exp_wr[k])
        $display("FAIL single_wr%0d: got mask=%h addr=%0d d=%h required mask=%h addr=%0d d=%h", k,
                 obs_wr[wr_base+k].mask, obs_wr[wr_base+k].addr, obs_wr[wr_base+k].data[31:0],
                 exp_wr[k].mask, exp_wr[k].addr, exp_wr[k].data[31:0]);
      else n_pass++;
    end
    n_checks++;
    if (rd_pulses - rd_base !== 1 || obs_rd_addr !== cur_off + AW'(cur_doff) || obs_rd_size !== XW'(cur_len))
      $display("FAIL single_rd: pulses=%0d addr=%h size=%h required 1 %h %h", rd_pulses - rd_base,
               obs_rd_addr, obs_rd_size, cur_off + AW'(cur_doff), XW'(cur_len));
    else n_pass++;
    n_checks++;
    if (done_pulses - done_base !== 1 || done_cyc - acc_cyc !== 2)
      $display("FAIL single_done: pulses=%0d latency=%0d required 1 and 2", done_pulses - done_base, done_cyc - acc_cyc);
    else n_pass++;
    $display("txn single: bank2 S=10 N=4 writes=%0d", obs_wr.size() - wr_base);
  endtask

  task automatic test_interleave();
    start_txn(2'd2, 4'd0, 16'd0, 16'd8);
    send_beats(8, 8, 1'b0, 1'b0);
    wait_done();
    build_expected();
    n_checks++;
    if (obs_wr.size() - wr_base !== 8) $display("FAIL ilv_count: got %0d writes required 8", obs_wr.size() - wr_base);
    else n_pass++;
    for (int k = 0; k < exp_wr.size() && wr_base + k < obs_wr.size(); k++) begin
      n_checks++;
      if (obs_wr[wr_base+k] !== exp_wr[k])
        $display("FAIL ilv_wr%0d: got mask=%h addr=%0d required mask=%h addr=%0d", k,
                 obs_wr[wr_base+k].mask, obs_wr[wr_base+k].addr, exp_wr[k].mask, exp_wr[k].addr);
      else n_pass++;
    end
    $display("txn interleave: S=0 N=8 writes=%0d", obs_wr.size() - wr_base);
  endtask

  task automatic test_backpressure_wrap();
    start_txn(2'd1, 4'd3, 16'd510, 16'd4);
    send_beats(4, 4, 1'b1, 1'b0);
    wait_done();
    build_expected();
    n_checks++;
    if (obs_wr.size() - wr_base !== 4) $display("FAIL wrap_count: got %0d writes required 4", obs_wr.size() - wr_base);
    else n_pass++;
    for (int k = 0; k < exp_wr.size() && wr_base + k < obs_wr.size(); k++) begin
      n_checks++;
      if (obs_wr[wr_base+k] !== exp_wr[k])
        $display("FAIL wrap_wr%0d: got mask=%h addr=%0d required mask=%h addr=%0d", k,
                 obs_wr[wr_base+k].mask, obs_wr[wr_base+k].addr, exp_wr[k].mask, exp_wr[k].addr);
      else n_pass++;
    end
    $display("txn broadcast_wrap: S=510 N=4 writes=%0d", obs_wr.size() - wr_base);
  endtask

  task automatic test_zero();
    start_txn(2'd0, 4'd1, 16'd7, 16'd0);
    wait_done();
    n_checks++;
    if (rd_pulses - rd_base !== 0) $display("FAIL zero_rd: rd_start pulses=%0d required 0", rd_pulses - rd_base);
    else n_pass++;
    n_checks++;
    if (done_pulses - done_base !== 1 || done_cyc - start_cyc !== 3)
      $display("FAIL zero_done: pulses=%0d latency=%0d required 1 and 3", done_pulses - done_base, done_cyc - start_cyc);
    else n_pass++;
    n_checks++;
    if (obs_wr.size() - wr_base !== 0) $display("FAIL zero_wr: got %0d writes required 0", obs_wr.size() - wr_base);
    else n_pass++;
    $display("txn zero: N=0");
  endtask

  task automatic test_long();
    start_txn(2'd0, 4'd3, 16'd40, 16'd2);
    send_beats(5, 5, 1'b0, 1'b0);
    wait_done();
    build_expected();
    n_checks++;
    if (obs_wr.size() - wr_base !== 2 || sent.size() !== 5)
      $display("FAIL long_count: got %0d writes of %0d beats required 2 of 5", obs_wr.size() - wr_base, sent.size());
    else n_pass++;
    n_checks++;
    if (obs_wr.size() - wr_base >= 2 && obs_wr[wr_base+1] !== exp_wr[1])
      $display("FAIL long_wr1: got addr=%0d required addr=%0d", obs_wr[wr_base+1].addr, exp_wr[1].addr);
    else n_pass++;
    n_checks++;
    if (done_pulses - done_base !== 1 || done_cyc - acc_cyc !== 2)
      $display("FAIL long_done: pulses=%0d latency=%0d required 1 and 2", done_pulses - done_base, done_cyc - acc_cyc);
    else n_pass++;
`ifdef BIAS_LOAD_ERR_STATUS_EN
    n_checks++;
    if (obs_err !== 2'b10) $display("FAIL long_err: err_status=%b required 10", obs_err);
    else n_pass++;
`endif
    $display("txn long: N=2 beats=5");
  endtask

  task automatic test_short();
    start_txn(2'd3, 4'd1, 16'd200, 16'd6);
    send_beats(3, 3, 1'b0, 1'b0);
    wait_done();
    build_expected();
    n_checks++;
    if (obs_wr.size() - wr_base !== 3) $display("FAIL short_count: got %0d writes required 3", obs_wr.size() - wr_base);
    else n_pass++;
    n_checks++;
    if (obs_wr.size() - wr_base >= 3 && obs_wr[wr_base+2] !== exp_wr[2])
      $display("FAIL short_wr2: got mask=%h addr=%0d required mask=%h addr=%0d",
               obs_wr[wr_base+2].mask, obs_wr[wr_base+2].addr, exp_wr[2].mask, exp_wr[2].addr);
    else n_pass++;
    n_checks++;
    if (done_pulses - done_base !== 1 || done_cyc - acc_cyc !== 2)
      $display("FAIL short_done: pulses=%0d latency=%0d required 1 and 2", done_pulses - done_base, done_cyc - acc_cyc);
    else n_pass++;
`ifdef BIAS_LOAD_ERR_STATUS_EN
    n_checks++;
    if (obs_err !== 2'b01) $display("FAIL short_err: err_status=%b required 01", obs_err);
    else n_pass++;
`endif
    $display("txn short: N=6 tlast on beat 3");
  endtask

  task automatic test_abort();
    start_txn(2'd0, 4'd1, 16'd100, 16'd6);
    send_beats(2, 0, 1'b0, 1'b0);
    #2 kernel_rst = 1'b1;
    #1;
    n_checks++;
    if ({s_tready, ap_done, rd_start, buf_wr_valid} !== '0 || buf_wr_addr !== '0 || buf_wr_data !== '0)
      $display("FAIL abort_outputs: tready/done/rd/valid=%b addr=%h required all 0",
               {s_tready, ap_done, rd_start, buf_wr_valid}, buf_wr_addr);
    else n_pass++;
    @(posedge kernel_clk); #1;
    kernel_rst = 1'b0;
    wr_base = obs_wr.size(); done_base = done_pulses;
    repeat (6) begin @(posedge kernel_clk); #1; end
    n_checks++;
    if (obs_wr.size() - wr_base !== 0 || done_pulses - done_base !== 0)
      $display("FAIL abort_quiet: writes=%0d done=%0d required 0 and 0", obs_wr.size() - wr_base, done_pulses - done_base);
    else n_pass++;
    start_txn(2'd0, 4'd1, 16'd20, 16'd3);
    send_beats(3, 3, 1'b0, 1'b0);
    wait_done();
    build_expected();
    n_checks++;
    if (obs_wr.size() - wr_base !== 3 || done_pulses - done_base !== 1)
      $display("FAIL abort_rerun: writes=%0d done=%0d required 3 and 1", obs_wr.size() - wr_base, done_pulses - done_base);
    else n_pass++;
    for (int k = 0; k < exp_wr.size() && wr_base + k < obs_wr.size(); k++) begin
      n_checks++;
      if (obs_wr[wr_base+k] !== exp_wr[k])
        $display("FAIL abort_wr%0d: got mask=%h addr=%0d required mask=%h addr=%0d", k,
                 obs_wr[wr_base+k].mask, obs_wr[wr_base+k].addr, exp_wr[k].mask, exp_wr[k].addr);
      else n_pass++;
    end
    $display("txn abort: reset mid-stream then rerun");
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      logic [1:0]  m;
      logic [15:0] s, n;
      int          nb, exp_lat, exp_rd;
      bit          tog, noise;
      logic [1:0]  exp_err;
      m = 2'($urandom_range(0, 3)); s = 16'($urandom()); n = 16'($urandom_range(0, 9));
      nb = (n == 0) ? 0 : int'($urandom_range(1, int'(n) + 3));
      tog = 1'($urandom()); noise = 1'($urandom());
      start_txn(m, 4'($urandom()), s, n);
      if (nb > 0) send_beats(nb, nb, tog, noise);
      wait_done();
      build_expected();
      exp_rd  = (n != 0) ? 1 : 0;
      exp_lat = (n == 0) ? start_cyc + 3 : acc_cyc + 2;
      exp_err = (n == 0 || nb == int'(n)) ? 2'b00 : (nb < int'(n)) ? 2'b01 : 2'b10;
      n_checks++;
      if (obs_wr.size() - wr_base !== exp_wr.size())
        $display("FAIL rnd%0d_count: got %0d writes required %0d", t, obs_wr.size() - wr_base, exp_wr.size());
      else n_pass++;
      for (int k = 0; k < exp_wr.size() && wr_base + k < obs_wr.size(); k++) begin
        n_checks++;
        if (obs_wr[wr_base+k] !== exp_wr[k])
          $display("FAIL rnd%0d_wr%0d: got mask=%h addr=%0d d=%h required mask=%h addr=%0d d=%h", t, k,
                   obs_wr[wr_base+k].mask, obs_wr[wr_base+k].addr, obs_wr[wr_base+k].data[31:0],
                   exp_wr[k].mask, exp_wr[k].addr, exp_wr[k].data[31:0]);
        else n_pass++;
      end
      n_checks++;
      if (rd_pulses - rd_base !== exp_rd ||
          (exp_rd == 1 && (obs_rd_addr !== cur_off + AW'(cur_doff) || obs_rd_size !== XW'(cur_len))))
        $display("FAIL rnd%0d_rd: pulses=%0d addr=%h size=%h required %0d %h %h", t, rd_pulses - rd_base,
                 obs_rd_addr, obs_rd_size, exp_rd, cur_off + AW'(cur_doff), XW'(cur_len));
      else n_pass++;
      n_checks++;
      if (done_pulses - done_base !== 1 || done_cyc !== exp_lat)
        $display("FAIL rnd%0d_done: pulses=%0d cycle=%0d required 1 and %0d", t, done_pulses - done_base, done_cyc, exp_lat);
      else n_pass++;
`ifdef BIAS_LOAD_ERR_STATUS_EN
      n_checks++;
      if (obs_err !== exp_err) $display("FAIL rnd%0d_err: err_status=%b required %b", t, obs_err, exp_err);
      else n_pass++;
`endif
      $display("txn rnd%0d: mode=%0d S=%0d N=%0d beats=%0d toggle=%0d err=%b", t, m, s, n, nb, tog, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_backpressure_wrap();
    test_zero();
    test_long();
    test_short();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
